// File: rtl/thor2024_pc_gen_pkg.sv
// Shared types for the Thor2024 fetch-PC generator: address type, reset PC and FSM/action enums.
package Thor2024pkg;

    typedef logic [31:0] pc_address_t;

    localparam pc_address_t RSTPC = 32'hFFFD0000;

    typedef enum logic [1:0] {
        StRun,
        StMicro,
        StBoot
    } pc_state_e;

    typedef enum logic [1:0] {
        ActHold,
        ActStep,
        ActBack,
        ActMiss
    } pc_act_e;

    // One fetch-buffer group: slot A/B valid and backward-branch flags.
    typedef struct packed {
        logic valid;
        logic a;
        logic b;
        logic ba;
        logic bb;
    } fb_pair_t;

endpackage

// File: rtl/thor2024_pc_gen.sv
// Fetch PC / micro-IP generator: selects between mispredict redirect, backward-branch
// reload and sequential/microcode advance each cycle.
module thor2024_pc_gen #(
    parameter int unsigned      PCW        = 32,
    parameter int unsigned      MCW        = 12,
    parameter int unsigned      NGRP       = 2,
    parameter logic [PCW-1:0]   RSTPC      = PCW'(32'hFFFD0000),
    parameter logic [PCW-1:0]   MC_RET_INC = PCW'(32'h5000)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      irq,
    input  logic                      stall,
    input  logic                      hit,
    input  logic [PCW-1:0]            next_pc,
    input  logic                      micro_entry,
    input  logic [MCW-1:0]            micro_entry_ip,
    input  logic [MCW-1:0]            next_micro_ip,
    input  logic                      branchmiss,
    input  logic [PCW-1:0]            misspc,
    input  logic                      branchback,
    input  logic                      did_branchback,
    input  logic [PCW-1:0]            backpc,
    input  logic [MCW-1:0]            back_micro_ip,
    input  logic [$clog2(NGRP)-1:0]   fb_sel,
    input  logic [2*NGRP-1:0]         fb_v,
    input  logic [2*NGRP-1:0]         backbr,
    output logic [PCW-1:0]            pc,
    output logic [MCW-1:0]            micro_ip,
    output logic                      pc_v,
    output logic                      redirect
);

    import Thor2024pkg::*;

    pc_state_e      state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [MCW-1:0] micro_ip_q, micro_ip_d;
    logic           redirect_q, redirect_d;

    pc_act_e        act;
    fb_pair_t       sel_pair;
    fb_pair_t       grp_pair;
    logic           any_empty;

    // Out-of-range group index yields valid=0, which the caller treats as hold.
    function automatic fb_pair_t thor2024_fb_pair(input logic [2*NGRP-1:0] v,
                                                  input logic [2*NGRP-1:0] bk,
                                                  input int unsigned       g);
        fb_pair_t p;
        p = '0;
        if (g < NGRP) begin
            p.valid = 1'b1;
            p.a     = v[2*g];
            p.b     = v[2*g+1];
            p.ba    = bk[2*g];
            p.bb    = bk[2*g+1];
        end
        return p;
    endfunction

    always_comb begin
        act       = ActHold;
        sel_pair  = thor2024_fb_pair(fb_v, backbr, int'(unsigned'(fb_sel)));
        grp_pair  = '0;
        any_empty = 1'b0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            grp_pair = thor2024_fb_pair(fb_v, backbr, g);
            if (!grp_pair.a && !grp_pair.b) any_empty = 1'b1;
        end

        if (state_q != StBoot) begin
            if (branchmiss) begin
                act = ActMiss;
            end else if (branchback) begin
                if (sel_pair.valid) begin
                    case ({sel_pair.a, sel_pair.b})
                        2'b01:   act = sel_pair.bb ? ActStep : ActHold;
                        2'b10:   act = sel_pair.ba ? ActStep : ActHold;
                        2'b11: begin
                            if (sel_pair.ba)      act = ActBack;
                            else if (sel_pair.bb) act = did_branchback ? ActStep : ActBack;
                            else                  act = ActHold;
                        end
                        default: act = ActHold;
                    endcase
                end
            end else if (any_empty) begin
                act = ActStep;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        micro_ip_d = micro_ip_q;
        redirect_d = 1'b0;

        if (state_q == StBoot) begin
            state_d = StRun;
        end

        unique case (act)
            ActMiss: begin
                pc_d       = misspc;
                micro_ip_d = '0;
                state_d    = StRun;
                redirect_d = 1'b1;
            end
            ActBack: begin
                pc_d       = backpc;
                micro_ip_d = back_micro_ip;
                state_d    = (back_micro_ip != '0) ? StMicro : StRun;
                redirect_d = 1'b1;
            end
            ActStep: begin
                if (!irq && !stall) begin
                    if (state_q == StRun) begin
                        if (hit) begin
                            if (micro_entry) begin
                                micro_ip_d = micro_entry_ip;
                                state_d    = StMicro;
                            end else begin
                                pc_d = next_pc;
                            end
                        end
                    end else if (state_q == StMicro) begin
                        if (next_micro_ip != '0) begin
                            micro_ip_d = next_micro_ip;
                        end else begin
                            pc_d       = pc_q + MC_RET_INC;
                            micro_ip_d = '0;
                            state_d    = StRun;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RSTPC;
            micro_ip_q <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            micro_ip_q <= micro_ip_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc       = pc_q;
    assign micro_ip = micro_ip_q;
    assign pc_v     = (state_q != StBoot);
    assign redirect = redirect_q;

endmodule

// File: tb/tb_thor2024_pc_gen.sv
// Directed bench for thor2024_pc_gen (NGRP=4): reset, sequential, microcode, branchback,
// and simultaneous-event priority.
module tb_thor2024_pc_gen;

    localparam logic [31:0] RST_PC = 32'hFFFD0000;
    localparam logic [31:0] RET_INC = 32'h5000;

    logic        clk = 1'b0;
    logic        rst, irq, stall, hit;
    logic [31:0] next_pc;
    logic        micro_entry;
    logic [11:0] micro_entry_ip, next_micro_ip;
    logic        branchmiss;
    logic [31:0] misspc;
    logic        branchback, did_branchback;
    logic [31:0] backpc;
    logic [11:0] back_micro_ip;
    logic [1:0]  fb_sel;
    logic [7:0]  fb_v, backbr;
    logic [31:0] pc;
    logic [11:0] micro_ip;
    logic        pc_v, redirect;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;

    thor2024_pc_gen #(
        .PCW (32),
        .MCW (12),
        .NGRP(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .irq           (irq),
        .stall         (stall),
        .hit           (hit),
        .next_pc       (next_pc),
        .micro_entry   (micro_entry),
        .micro_entry_ip(micro_entry_ip),
        .next_micro_ip (next_micro_ip),
        .branchmiss    (branchmiss),
        .misspc        (misspc),
        .branchback    (branchback),
        .did_branchback(did_branchback),
        .backpc        (backpc),
        .back_micro_ip (back_micro_ip),
        .fb_sel        (fb_sel),
        .fb_v          (fb_v),
        .backbr        (backbr),
        .pc            (pc),
        .micro_ip      (micro_ip),
        .pc_v          (pc_v),
        .redirect      (redirect)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        irq = 0; stall = 0; hit = 0; next_pc = '0;
        micro_entry = 0; micro_entry_ip = '0; next_micro_ip = '0;
        branchmiss = 0; misspc = '0; branchback = 0; did_branchback = 0;
        backpc = '0; back_micro_ip = '0; fb_sel = '0; fb_v = '0; backbr = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        n_checks++;
        if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_checks++;
        if (pc_v !== 1'b0) begin n_fail++; $display("FAIL reset_pc_v: got %b want 0", pc_v); end
        n_checks++;
        if (micro_ip !== 12'h0) begin n_fail++; $display("FAIL reset_uip: got %h want 0", micro_ip); end
        rst = 0;
        #1;
        n_checks++;
        if (pc_v !== 1'b0) begin n_fail++; $display("FAIL boot_pc_v: got %b want 0", pc_v); end
        tick();
        n_checks++;
        if (pc_v !== 1'b1) begin n_fail++; $display("FAIL run_pc_v: got %b want 1", pc_v); end
        n_checks++;
        if (pc !== RST_PC) begin n_fail++; $display("FAIL run_pc: got %h want %h", pc, RST_PC); end
        exp_pc = RST_PC;
    endtask

    task automatic test_seq();
        clear_inputs();
        hit = 1;
        for (int i = 0; i < 3; i++) begin
            next_pc = exp_pc + 32'd5;
            tick();
            exp_pc = exp_pc + 32'd5;
            n_checks++;
            if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp_pc); end
        end
        next_pc = exp_pc + 32'd5;
        hit = 0;
        tick();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_miss_hold: got %h want %h", pc, exp_pc); end
        hit = 1; stall = 1;
        tick();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_stall_hold: got %h want %h", pc, exp_pc); end
        stall = 0; irq = 1;
        tick();
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_irq_hold: got %h want %h", pc, exp_pc); end
        irq = 0;
        tick();
        exp_pc = exp_pc + 32'd5;
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL seq_resume: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_micro();
        clear_inputs();
        hit = 1; micro_entry = 1; micro_entry_ip = 12'h010; next_pc = exp_pc + 32'd5;
        tick();
        n_checks++;
        if (micro_ip !== 12'h010) begin n_fail++; $display("FAIL mc_entry_uip: got %h want 010", micro_ip); end
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL mc_entry_pc: got %h want %h", pc, exp_pc); end
        micro_entry = 0; hit = 0; next_micro_ip = 12'h011;
        tick();
        n_checks++;
        if (micro_ip !== 12'h011) begin n_fail++; $display("FAIL mc_step_uip: got %h want 011", micro_ip); end
        irq = 1; next_micro_ip = 12'h000;
        tick();
        n_checks++;
        if (micro_ip !== 12'h011) begin n_fail++; $display("FAIL mc_irq_freeze: got %h want 011", micro_ip); end
        irq = 0;
        tick();
        exp_pc = exp_pc + RET_INC;
        n_checks++;
        if (micro_ip !== 12'h000) begin n_fail++; $display("FAIL mc_exit_uip: got %h want 000", micro_ip); end
        n_checks++;
        if (pc !== exp_pc) begin n_fail++; $display("FAIL mc_exit_pc: got %h want %h", pc, exp_pc); end
    endtask

    task automatic test_branchback();
        clear_inputs();
        fb_sel = 2'd2; fb_v = 8'h30; backbr = 8'h10; branchback = 1;
        backpc = 32'h100; hit = 1; next_pc = 32'hDEAD0000;
        tick();
        n_checks++;
        if (pc !== 32'h100) begin n_fail++; $display("FAIL bb_load_pc: got %h want 00000100", pc); end
        n_checks++;
        if (redirect !== 1'b1) begin n_fail++; $display("FAIL bb_redirect: got %b want 1", redirect); end
        backbr = 8'h20; did_branchback = 1; next_pc = 32'h104;
        tick();
        n_checks++;
        if (pc !== 32'h104) begin n_fail++; $display("FAIL bb_did_step: got %h want 00000104", pc); end
        n_checks++;
        if (redirect !== 1'b0) begin n_fail++; $display("FAIL bb_redirect_pulse: got %b want 0", redirect); end
        // bB only, not yet taken: reload into microcode, ignoring stall
        did_branchback = 0; backpc = 32'h200; back_micro_ip = 12'h020; stall = 1;
        tick();
        n_checks++;
        if (pc !== 32'h200 || micro_ip !== 12'h020) begin
            n_fail++; $display("FAIL bb_back_micro: got %h/%h want 00000200/020", pc, micro_ip);
        end
        stall = 0; branchback = 0; fb_v = 8'hFF; next_micro_ip = 12'h000;
        tick();
        n_checks++;
        if (pc !== 32'h200 || micro_ip !== 12'h020) begin
            n_fail++; $display("FAIL fb_full_hold: got %h/%h want 00000200/020", pc, micro_ip);
        end
        fb_v = 8'h3F;
        tick();
        n_checks++;
        if (pc !== 32'h5200 || micro_ip !== 12'h000) begin
            n_fail++; $display("FAIL fb_empty_step: got %h/%h want 00005200/000", pc, micro_ip);
        end
        branchback = 1; fb_v = 8'h0F; backbr = 8'h00; next_pc = 32'h5205;
        tick();
        n_checks++;
        if (pc !== 32'h5200) begin n_fail++; $display("FAIL bb_00_hold: got %h want 00005200", pc); end
        fb_v = 8'h10; backbr = 8'h10;
        tick();
        n_checks++;
        if (pc !== 32'h5205) begin n_fail++; $display("FAIL bb_10_step: got %h want 00005205", pc); end
        exp_pc = 32'h5205;
    endtask

    task automatic test_simultaneous();
        clear_inputs();
        branchmiss = 1; branchback = 1; irq = 1; misspc = 32'h2000;
        fb_sel = 2'd2; fb_v = 8'h30; backbr = 8'h10; backpc = 32'h100;
        tick();
        n_checks++;
        if (pc !== 32'h2000 || micro_ip !== 12'h000) begin
            n_fail++; $display("FAIL miss_priority: got %h/%h want 00002000/000", pc, micro_ip);
        end
        n_checks++;
        if (redirect !== 1'b1) begin n_fail++; $display("FAIL miss_redirect: got %b want 1", redirect); end
        // branchmiss from inside microcode
        clear_inputs();
        hit = 1; micro_entry = 1; micro_entry_ip = 12'h040;
        tick();
        micro_entry = 0; branchmiss = 1; misspc = 32'h3000; next_micro_ip = 12'h041;
        tick();
        n_checks++;
        if (pc !== 32'h3000 || micro_ip !== 12'h000) begin
            n_fail++; $display("FAIL miss_from_micro: got %h/%h want 00003000/000", pc, micro_ip);
        end
        // reset mid-microcode with concurrent branchmiss/branchback
        clear_inputs();
        hit = 1; micro_entry = 1; micro_entry_ip = 12'h050;
        tick();
        micro_entry = 0; rst = 1; branchmiss = 1; misspc = 32'h4000;
        branchback = 1; fb_sel = 2'd2; fb_v = 8'h30; backbr = 8'h10; backpc = 32'h100;
        tick();
        n_checks++;
        if (pc !== RST_PC || micro_ip !== 12'h000 || redirect !== 1'b0 || pc_v !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wins: got pc=%h uip=%h redir=%b v=%b want %h/000/0/0",
                     pc, micro_ip, redirect, pc_v, RST_PC);
        end
        rst = 0;
        clear_inputs();
        tick();
        n_checks++;
        if (pc_v !== 1'b1 || pc !== RST_PC) begin
            n_fail++; $display("FAIL rst_recover: got v=%b pc=%h want 1/%h", pc_v, pc, RST_PC);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_seq();
        test_micro();
        test_branchback();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/thor2024_pc_gen.md
THOR2024_PC_GEN -- requirements
Module: thor2024_pc_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PCW  32  PC width in bits
  MCW  12  micro-IP width in bits
  NGRP  2  number of fetch-buffer groups (pairs); power of 2, >=2
  RSTPC  32'hFFFD0000  reset PC
  MC_RET_INC  32'h5000  PC increment applied on return from microcode
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  clock, rising edge
  rst  in  1  reset, synchronous, active-high
  irq  in  1  interrupt pending; suppresses sequential advance
  stall  in  1  back-pressure; suppresses sequential advance
  hit  in  1  I-cache hit for current pc
  next_pc  in  PCW  sequential/predicted next PC
  micro_entry  in  1  instruction at pc enters microcode
  micro_entry_ip  in  MCW  microcode entry address
  next_micro_ip  in  MCW  next micro-IP; 0 = microcode done
  branchmiss  in  1  mispredict redirect request
  misspc  in  PCW  redirect target
  branchback  in  1  backward branch present in fetch buffers
  did_branchback  in  1  branchback already taken for current group
  backpc  in  PCW  backward-branch target PC
  back_micro_ip  in  MCW  backward-branch target micro-IP
  fb_sel  in  $clog2(NGRP)  group currently being drained
  fb_v  in  2*NGRP  entry valid; entries 2g (slot A), 2g+1 (slot B) form group g
  backbr  in  2*NGRP  entry holds a backward branch; same indexing as fb_v
  pc  out  PCW  fetch PC
  micro_ip  out  MCW  current micro-IP; nonzero only in MICRO
  pc_v  out  1  pc valid for fetch this cycle
  redirect  out  1  one-cycle pulse: pc loaded from misspc or backpc last edge

Function
REQ-003 FSM states SHALL be RUN, MICRO, BOOT; BOOT is entered only from reset and always goes to RUN after one cycle, with pc_v=0 during BOOT and pc_v=1 otherwise.
REQ-004 An update SHALL be selected once per cycle, in priority order: branchmiss, then branchback, then sequential advance.
REQ-005 branchmiss (RUN or MICRO) SHALL load pc<=misspc and micro_ip<=0, enter RUN, and set redirect=1.
REQ-006 Step, when taken, SHALL be a no-op if irq or stall is 1; otherwise it SHALL behave as follows.
  RUN, hit=1: with micro_entry=0, pc<=next_pc; with micro_entry=1, micro_ip<=micro_entry_ip, pc unchanged, enter MICRO.
  RUN, hit=0: hold.
  MICRO, next_micro_ip!=0: micro_ip<=next_micro_ip, independent of hit.
  MICRO, next_micro_ip==0: pc<=pc+MC_RET_INC modulo 2^PCW, micro_ip<=0, enter RUN.
REQ-007 With branchback=1, let {A,B}={fb_v[2*fb_sel], fb_v[2*fb_sel+1]}, and let bA and bB be the matching backbr bits; the action SHALL be chosen by {A,B}.
  01: Step if bB; else hold.
  10: Step if bA; else hold.
  11, bA: load back.
  11, bB only: Step if did_branchback; else load back.
  00: hold.
REQ-008 Load back SHALL set pc<=backpc and micro_ip<=back_micro_ip, enter MICRO if back_micro_ip!=0 else RUN, and set redirect=1; it SHALL ignore irq and stall.
REQ-009 With branchback=0, Step SHALL occur only when at least one group g has fb_v[2g]=fb_v[2g+1]=0; otherwise hold.
REQ-010 redirect SHALL be 0 on every cycle not covered by REQ-005/REQ-008.
REQ-011 micro_ip SHALL equal 0 whenever state is RUN or BOOT.
REQ-012 An fb_sel value outside 0..NGRP-1 SHALL be treated as hold; X on unused inputs SHALL not propagate to pc while the inputs are ignored.

Reset
REQ-013 While rst=1 at a clock edge: pc<=RSTPC, micro_ip<=0, state<=BOOT, redirect<=0; this holds mid-microcode and over a concurrent branchmiss or branchback.
REQ-014 pc_v SHALL be 0 in the cycle after rst deasserts and 1 from the following cycle.

Structure
REQ-015 pc_address_t, RSTPC and the FSM state enum SHALL live in Thor2024pkg; no sub-modules are required.
REQ-016 Group selection (fb_v/backbr slice by fb_sel) SHALL be a single function thor2024_fb_pair, shared between the REQ-007 and REQ-009 paths.

Verification
REQ-017 Reset then idle: rst 2 cycles -> pc=RSTPC, pc_v 0 then 1, micro_ip=0.
REQ-018 Sequential advance: fb_v=0, hit=1, next_pc=pc+5 -> pc advances by 5 each cycle; hit=0 or stall=1 -> pc held.
REQ-019 Microcode: micro_entry=1, micro_entry_ip=12'h010, then next_micro_ip 12'h011, 0 -> micro_ip 10, 11, 0; pc+=32'h5000 on exit; irq=1 mid-sequence freezes micro_ip.
REQ-020 Branchback, NGRP=4, fb_sel=2: fb_v[5:4]=2'b11, backbr[4]=1, backpc=32'h100 -> pc=32'h100, redirect=1 for one cycle; then backbr[5] only with did_branchback=1 -> Step.
REQ-021 Simultaneous events: branchmiss with branchback and irq, misspc=32'h2000 -> pc=32'h2000, micro_ip=0; rst during the same cycle -> RSTPC wins.
